// File: rtl/rho_rotate_engine_pkg.sv
// Shared definitions for the rho rotation engine: slice geometry, FSM states
// and the Keccak rho offset table.
package rho_rotate_engine_pkg;

  // One slice holds bit z of all 25 lanes; bit x+5*y belongs to lane (x,y).
  localparam int SLICE_W = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Keccak rho offsets, entry x+5*y is r[x][y] (full 64-bit lane values).
  localparam int unsigned RHO_OFF [SLICE_W] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

endpackage

// File: rtl/rho_rotate_engine_if.sv
// Slice streaming interface of the rho rotation engine: pass control, input
// slice handshake, output slice handshake and status.
interface rho_rotate_engine_if
  import rho_rotate_engine_pkg::*;
#(
  parameter int LANE_W = 64
);
  localparam int IDX_W = $clog2(LANE_W);

  logic               start;
  logic               inv;
  logic               in_valid;
  logic               in_ready;
  logic [SLICE_W-1:0] in_slice;
  logic               out_valid;
  logic               out_ready;
  logic [SLICE_W-1:0] out_slice;
  logic [IDX_W-1:0]   out_index;
  logic               busy;
  logic               done;

  modport master (
    output start, inv, in_valid, in_slice, out_ready,
    input  in_ready, out_valid, out_slice, out_index, busy, done
  );

  modport slave (
    input  start, inv, in_valid, in_slice, out_ready,
    output in_ready, out_valid, out_slice, out_index, busy, done
  );

endinterface

// File: rtl/rho_slice_select.sv
// Combinational slice picker: for output slice idx, each lane bit is taken
// from the buffered slice displaced by that lane's rho offset (subtracted for
// the forward rotation, added for the inverse), all modulo LANE_W.
module rho_slice_select
  import rho_rotate_engine_pkg::*;
#(
  parameter  int LANE_W = 64,
  localparam int IDX_W  = $clog2(LANE_W)
) (
  input  logic [LANE_W-1:0][SLICE_W-1:0] buffer,
  input  logic [IDX_W-1:0]               idx,
  input  logic                           inv,
  output logic [SLICE_W-1:0]             slice
);

  for (genvar i = 0; i < SLICE_W; i++) begin : g_lane
    // Truncating to IDX_W bits is the mod LANE_W reduction (LANE_W is 2^n).
    localparam logic [IDX_W-1:0] OFF = IDX_W'(RHO_OFF[i]);
    logic [IDX_W-1:0] src;

    assign src      = inv ? (idx + OFF) : (idx - OFF);
    assign slice[i] = buffer[src][i];
  end

endmodule

// File: rtl/rho_rotate_engine.sv
// Rho rotation engine: loads LANE_W slices into a register buffer, then
// streams them back out rotated lane-by-lane by the Keccak rho offsets.
module rho_rotate_engine
  import rho_rotate_engine_pkg::*;
#(
  parameter  int LANE_W = 64,
  localparam int IDX_W  = $clog2(LANE_W)
) (
  input logic                clk,
  input logic                rst,
  rho_rotate_engine_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANE_W - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t                        state_q;
  state_t                        state_d;
  logic [IDX_W-1:0]              load_cnt;
  logic [IDX_W-1:0]              emit_cnt;
  logic                          inv_q;
  logic [LANE_W-1:0][SLICE_W-1:0] buffer;
  logic [SLICE_W-1:0]            sel_slice;
  logic                          load_hs;
  logic                          emit_hs;

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_EMIT);
  assign bus.busy      = (state_q == ST_LOAD) || (state_q == ST_EMIT);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.out_index = emit_cnt;
  assign bus.out_slice = bus.out_valid ? sel_slice : '0;

  assign load_hs = bus.in_valid  && bus.in_ready;
  assign emit_hs = bus.out_valid && bus.out_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one pass walks IDLE -> LOAD -> EMIT -> DONE -> IDLE.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start)                 state_d = ST_LOAD;
      ST_LOAD: if (load_hs && load_cnt == LAST) state_d = ST_EMIT;
      ST_EMIT: if (emit_hs && emit_cnt == LAST) state_d = ST_DONE;
      ST_DONE:                                  state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
  end

  // Slot counters and mode latch; counters wrap naturally at LANE_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt <= '0;
      emit_cnt <= '0;
      inv_q    <= 1'b0;
    end else if (state_q == ST_IDLE && bus.start) begin
      load_cnt <= '0;
      emit_cnt <= '0;
      inv_q    <= bus.inv;
    end else begin
      if (load_hs) load_cnt <= load_cnt + ONE;
      if (emit_hs) emit_cnt <= emit_cnt + ONE;
    end
  end

  // Slice buffer, written in arrival order during LOAD.
  // NOTE: the buffer is reset so an aborted pass cannot leak stale slices to
  // the output; it is a flop array, not a RAM, so the reset is legal here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          buffer           <= '0;
    else if (load_hs) buffer[load_cnt] <= bus.in_slice;
  end

  rho_slice_select #(
    .LANE_W (LANE_W)
  ) u_select (
    .buffer (buffer),
    .idx    (emit_cnt),
    .inv    (inv_q),
    .slice  (sel_slice)
  );

endmodule

// File: tb/tb_rho_rotate_engine.sv
// Self-checking bench for rho_rotate_engine: hand-computed one-hot vectors,
// randomized passes against a lane-rotation reference model, backpressure,
// mid-pass start/inv, and reset abort, at LANE_W 64 and 8.
module tb_rho_rotate_engine;

  typedef logic [24:0] slice_t;

  typedef struct {
    int   w;
    logic inv;
    int   lane;
    int   load_z;
    int   exp_z;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   done_seen64 = 0;
  int   done_seen8 = 0;

  slice_t ldq[$];
  slice_t expq[$];
  vec_t   vecs [12];

  // Rho offsets as a [y][x] table.
  int rho_tb [5][5] = '{
    '{ 0,  1, 62, 28, 27},
    '{36, 44,  6, 55, 20},
    '{ 3, 10, 43, 25, 39},
    '{41, 45, 15, 21,  8},
    '{18,  2, 61, 56, 14}
  };

  always #5 clk = ~clk;

  rho_rotate_engine_if #(.LANE_W(64)) bus64 ();
  rho_rotate_engine_if #(.LANE_W(8))  bus8 ();

  rho_rotate_engine #(.LANE_W(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
  rho_rotate_engine #(.LANE_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  always @(negedge clk) begin
    if (bus64.done === 1'b1) done_seen64++;
    if (bus8.done === 1'b1)  done_seen8++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Lane (x,y) rotated by r: forward out[z] = in[z-r], inverse out[z] = in[z+r].
  function automatic slice_t model_slice(input int z, input logic inv_v);
    int     w = ldq.size();
    slice_t s = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        int r   = rho_tb[y][x] % w;
        int src = inv_v ? (z + r) % w : (z + w - r) % w;
        s[x + 5*y] = ldq[src][x + 5*y];
      end
    end
    return s;
  endfunction

  task automatic build_onehot(input vec_t v);
    slice_t t = '0;
    t[v.lane] = 1'b1;
    ldq.delete();
    expq.delete();
    for (int k = 0; k < v.w; k++) begin
      ldq.push_back('0);
      expq.push_back('0);
    end
    ldq[v.load_z]  = t;
    expq[v.exp_z] = t;
  endtask

  task automatic build_random(input int w, input logic inv_v);
    ldq.delete();
    expq.delete();
    for (int k = 0; k < w; k++) ldq.push_back(slice_t'($urandom));
    for (int k = 0; k < w; k++) expq.push_back(model_slice(k, inv_v));
  endtask

  task automatic pass64(input logic inv_v, input bit gaps, input bit bp, input int rst_at);
    int sent = 0, got = 0, guard = 0, hold = 0, d0 = done_seen64;
    bit hs;
    // In_valid in IDLE must not write anything.
    bus64.start = 1'b1; bus64.inv = inv_v;
    bus64.in_valid = 1'b1; bus64.in_slice = '1;
    @(posedge clk); #1;
    bus64.start = 1'b0;
    check("load_in_ready", bus64.in_ready, 1);
    check("load_busy", bus64.busy, 1);
    check("load_out_valid", bus64.out_valid, 0);
    while (sent < 64 && guard < 2000) begin
      bus64.in_valid = !(gaps && $urandom_range(3) == 0);
      bus64.in_slice = bus64.in_valid ? ldq[sent] : slice_t'($urandom);
      if (sent == 20) begin bus64.start = 1'b1; bus64.inv = ~inv_v; end
      hs = bus64.in_valid && bus64.in_ready;
      @(posedge clk); #1;
      bus64.start = 1'b0;
      if (hs) sent++;
      guard++;
    end
    bus64.in_valid = 1'b0;
    check("load_count", sent, 64);
    guard = 0;
    while (got < 64 && guard < 2000) begin
      guard++;
      check("emit_valid", bus64.out_valid, 1);
      if (bus64.out_valid !== 1'b1) break;
      check("emit_index", bus64.out_index, got);
      check("emit_slice", bus64.out_slice, expq[got]);
      if (got == rst_at) begin
        rst = 1'b1;
        #1;
        check("abort_out_valid", bus64.out_valid, 0);
        check("abort_out_slice", bus64.out_slice, 0);
        check("abort_out_index", bus64.out_index, 0);
        check("abort_busy", bus64.busy, 0);
        check("abort_in_ready", bus64.in_ready, 0);
        check("abort_done", bus64.done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus64.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_idle_busy", bus64.busy, 0);
        check("abort_no_done", done_seen64, d0);
        return;
      end
      bus64.out_ready = 1'b1;
      if (gaps && $urandom_range(3) == 0) bus64.out_ready = 1'b0;
      if (bp && got == 5 && hold < 3) begin bus64.out_ready = 1'b0; hold++; end
      if (got == 30) begin bus64.start = 1'b1; bus64.inv = ~inv_v; end
      hs = bus64.out_ready;
      @(posedge clk); #1;
      bus64.start = 1'b0;
      if (hs) got++;
    end
    bus64.out_ready = 1'b1;
    check("emit_count", got, 64);
    if (bp) check("stall_cycles", hold, 3);
    check("done_pulse", bus64.done, 1);
    check("done_not_busy", bus64.busy, 0);
    check("done_out_valid", bus64.out_valid, 0);
    @(posedge clk); #1;
    check("done_single", bus64.done, 0);
    check("idle_in_ready", bus64.in_ready, 0);
    check("done_count", done_seen64, d0 + 1);
  endtask

  task automatic pass8(input logic inv_v);
    int d0 = done_seen8, got = 0;
    bus8.start = 1'b1; bus8.inv = inv_v;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    check("w8_in_ready", bus8.in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      bus8.in_valid = 1'b1;
      bus8.in_slice = ldq[k];
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
    while (got < 8 && bus8.out_valid === 1'b1) begin
      check("w8_emit_index", bus8.out_index, got);
      check("w8_emit_slice", bus8.out_slice, expq[got]);
      @(posedge clk); #1;
      got++;
    end
    check("w8_emit_count", got, 8);
    check("w8_done_pulse", bus8.done, 1);
    @(posedge clk); #1;
    check("w8_done_single", bus8.done, 0);
    check("w8_done_count", done_seen8, d0 + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{64, 1'b0,  1,  0,  1};
    vecs[1]  = '{64, 1'b1,  1,  0, 63};
    vecs[2]  = '{64, 1'b0,  2,  0, 62};
    vecs[3]  = '{64, 1'b0,  0,  7,  7};
    vecs[4]  = '{64, 1'b1,  0,  7,  7};
    vecs[5]  = '{64, 1'b1, 24,  3, 53};
    vecs[6]  = '{64, 1'b0,  6, 30, 10};
    vecs[7]  = '{64, 1'b1, 18,  0, 43};
    vecs[8]  = '{ 8, 1'b0,  2,  0,  6};
    vecs[9]  = '{ 8, 1'b1,  1,  0,  7};
    vecs[10] = '{ 8, 1'b0, 23,  3,  3};
    vecs[11] = '{ 8, 1'b1, 10,  5,  2};

    bus64.start = 1'b0; bus64.inv = 1'b0; bus64.in_valid = 1'b0;
    bus64.in_slice = '0; bus64.out_ready = 1'b1;
    bus8.start = 1'b0; bus8.inv = 1'b0; bus8.in_valid = 1'b0;
    bus8.in_slice = '0; bus8.out_ready = 1'b1;

    #1;
    check("rst_in_ready", bus64.in_ready, 0);
    check("rst_out_valid", bus64.out_valid, 0);
    check("rst_out_slice", bus64.out_slice, 0);
    check("rst_out_index", bus64.out_index, 0);
    check("rst_busy", bus64.busy, 0);
    check("rst_done", bus64.done, 0);
    check("rst_w8_busy", bus8.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      build_onehot(vecs[i]);
      if (vecs[i].w == 64) pass64(vecs[i].inv, 1'b0, 1'b0, -1);
      else                 pass8(vecs[i].inv);
    end

    for (int n = 0; n < 3; n++) begin
      logic iv = logic'($urandom_range(1));
      build_random(64, iv);
      pass64(iv, 1'b1, 1'b0, -1);
    end

    build_random(64, 1'b0);
    pass64(1'b0, 1'b0, 1'b1, -1);

    build_random(64, 1'b1);
    pass64(1'b1, 1'b0, 1'b0, 10);
    build_random(64, 1'b1);
    pass64(1'b1, 1'b1, 1'b0, -1);

    for (int n = 0; n < 2; n++) begin
      logic iv = logic'(n);
      build_random(8, iv);
      pass8(iv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rho_rotate_engine.md
RHO_ROTATE_ENGINE -- requirements
Module: rho_rotate_engine

Interface
REQ-001 SHALL have parameter LANE_W, default 64, lane depth in bits (slices per state); legal values 8, 16, 32, 64.
REQ-002 SHALL have derived localparam IDX_W = $clog2(LANE_W), slice-index width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  begin a pass; sampled only in IDLE.
REQ-006 SHALL have port inv  in  1  0 = forward rotation, 1 = inverse; latched with start.
REQ-007 SHALL have port in_valid  in  1  input slice valid.
REQ-008 SHALL have port in_ready  out  1  engine accepts input slice.
REQ-009 SHALL have port in_slice  in  25  input slice; bit x+5*y = lane (x,y).
REQ-010 SHALL have port out_valid  out  1  output slice valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts output slice.
REQ-012 SHALL have port out_slice  out  25  rotated slice, same bit mapping.
REQ-013 SHALL have port out_index  out  IDX_W  z index of out_slice.
REQ-014 SHALL have port busy  out  1  high in LOAD and EMIT.
REQ-015 SHALL have port done  out  1  one-cycle pulse after last output handshake.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> EMIT -> DONE -> IDLE.
REQ-017 IDLE: start=1 SHALL latch inv, clear counters, enter LOAD next cycle; start in any other state SHALL be ignored.
REQ-018 LOAD: in_ready SHALL be 1; each in_valid&in_ready SHALL write in_slice to buffer slot load_cnt and increment load_cnt.
REQ-019 Handshake on load_cnt = LANE_W-1 SHALL enter EMIT next cycle; load_cnt wraps to 0.
REQ-020 EMIT: out_valid SHALL be 1, out_index = emit_cnt; out_slice bit (x,y) SHALL equal buffer[(emit_cnt - r[x][y]) mod LANE_W] bit (x,y) when inv=0, buffer[(emit_cnt + r[x][y]) mod LANE_W] when inv=1.
REQ-021 Offsets r[x][y] SHALL be reduced mod LANE_W (low IDX_W bits); index arithmetic SHALL wrap modulo LANE_W.
REQ-022 out_ready=0 SHALL hold out_slice, out_index, out_valid stable; emit_cnt advances only on out_valid&out_ready.
REQ-023 Handshake at emit_cnt = LANE_W-1 SHALL enter DONE; DONE asserts done=1 for exactly one cycle, then IDLE.
REQ-024 in_ready SHALL be 0 outside LOAD; out_valid SHALL be 0 outside EMIT; in_valid outside LOAD SHALL have no effect.
REQ-025 Lane (0,0) (r=0) SHALL pass through unrotated in both modes.
REQ-026 Output SHALL be combinational from registered buffer/counter state (zero added latency); no in-to-out combinational path.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, load_cnt=0, emit_cnt=0, inv latch=0, buffer=0.
REQ-028 During/after reset: in_ready=0, out_valid=0, out_slice=0, out_index=0, busy=0, done=0.
REQ-029 Reset mid-LOAD or mid-EMIT SHALL abort the pass; no done pulse.

Structure
REQ-030 Shared package SHALL hold 5x5 rho offset table (standard Keccak values, row y=0: 0,1,62,28,27; y=1: 36,44,6,55,20; y=2: 3,10,43,25,39; y=3: 41,45,15,21,8; y=4: 18,2,61,56,14), state enum, slice width 25.
REQ-031 One sub-module SHALL be natural: rho_slice_select (combinational, buffer + emit_cnt + inv -> out_slice).
REQ-032 Buffer SHALL be LANE_W x 25-bit register array; no external memory interface.

Verification
REQ-033 LANE_W=64, forward: slice0=25'h0000002, rest 0 -> slice 1 = 25'h0000002, all others 0; done pulses once.
REQ-034 LANE_W=64, inverse, same load -> slice 63 = 25'h0000002, others 0.
REQ-035 LANE_W=8, forward: slice0=25'h0000004 (lane (2,0), 62 mod 8=6) -> slice 6 = 25'h0000004.
REQ-036 Backpressure: out_ready=0 for 3 cycles at out_index 5 -> out_slice/out_index constant, no slice skipped or repeated.
REQ-037 start pulsed during LOAD and EMIT -> ignored; inv change mid-pass -> no effect.
REQ-038 rst asserted at out_index 10 -> outputs 0 same cycle, IDLE, no done; new pass afterwards completes correctly.
